// File: rtl/ptmch_pkg.sv
// ---------------------------------------------------------------------------
// ptmch_pkg
// Shared constants for the flash-command trigger generator:
//   - snooped flash opcodes and the trigger channel each one maps to
//   - channel indices and channel count
//   - opcode-capture FSM state type and encodings
//   - opc_decode(): opcode -> one-hot channel vector (all zero on no match)
// ---------------------------------------------------------------------------
package ptmch_pkg;

  localparam int NUM_CH = 5;

  localparam int CH_PRGEXCT = 0;
  localparam int CH_RDSTAT  = 1;
  localparam int CH_BLKERS  = 2;
  localparam int CH_PDREAD  = 3;
  localparam int CH_WRSTAT  = 4;

  localparam logic [7:0] OPC_PRGEXCT  = 8'h10;
  localparam logic [7:0] OPC_RDSTAT_A = 8'h0F;
  localparam logic [7:0] OPC_RDSTAT_B = 8'h05;
  localparam logic [7:0] OPC_BLKERS   = 8'hD8;
  localparam logic [7:0] OPC_PDREAD   = 8'h13;
  localparam logic [7:0] OPC_WRSTAT_A = 8'h1F;
  localparam logic [7:0] OPC_WRSTAT_B = 8'h01;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE    = 2'd0;
  localparam fsm_state_t ST_OPCODE  = 2'd1;
  localparam fsm_state_t ST_WAIT_CS = 2'd2;

  function automatic logic [NUM_CH-1:0] opc_decode(input logic [7:0] opc);
    logic [NUM_CH-1:0] ch;
    ch = '0;
    case (opc)
      OPC_PRGEXCT:                ch[CH_PRGEXCT] = 1'b1;
      OPC_RDSTAT_A, OPC_RDSTAT_B: ch[CH_RDSTAT]  = 1'b1;
      OPC_BLKERS:                 ch[CH_BLKERS]  = 1'b1;
      OPC_PDREAD:                 ch[CH_PDREAD]  = 1'b1;
      OPC_WRSTAT_A, OPC_WRSTAT_B: ch[CH_WRSTAT]  = 1'b1;
      default:                    ch = '0;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/ptmch_pls_stretch.sv
// ---------------------------------------------------------------------------
// ptmch_pls_stretch
// One trigger channel: turns single-cycle hits into PLS_WIDTH-cycle pulses
// separated by at least PLS_WIDTH low cycles. One hit arriving while the
// channel is busy is held as pending; a further hit while pending is lost
// and sets the sticky drop flag.
//   clk_i   in   system clock
//   rst_i   in   asynchronous active-high reset
//   hit_i   in   single-cycle decode hit for this channel
//   pls_o   out  registered trigger pulse
//   drop_o  out  sticky lost-hit flag
// ---------------------------------------------------------------------------
module ptmch_pls_stretch #(
  parameter int PLS_WIDTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hit_i,
  output logic pls_o,
  output logic drop_o
);

  localparam int CW = 5;
  // One down-counter spans high time plus gap: values above PLS_WIDTH are
  // the high phase, 1..PLS_WIDTH the gap, 0 means idle.
  localparam logic [CW-1:0] CNT_LOAD = CW'(2 * PLS_WIDTH - 1);
  localparam logic [CW-1:0] HI_LIMIT = CW'(PLS_WIDTH);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pls_q, pls_d;
  logic          pend_q, pend_d;
  logic          drop_q, drop_d;
  logic          busy;
  logic          start;

  always_comb begin
    busy   = (cnt_q != '0);
    start  = !busy && (hit_i || pend_q);
    cnt_d  = cnt_q;
    pend_d = pend_q;
    drop_d = drop_q;
    if (start) begin
      cnt_d  = CNT_LOAD;
      // pending pulse launches now; a hit in the same cycle becomes the new pending
      pend_d = pend_q && hit_i;
    end else begin
      if (busy) cnt_d = cnt_q - CW'(1);
      if (hit_i) begin
        if (pend_q) drop_d = 1'b1;
        pend_d = 1'b1;
      end
    end
    pls_d = start || (cnt_q > HI_LIMIT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      pls_q  <= 1'b0;
      pend_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pls_q  <= pls_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  assign pls_o  = pls_q;
  assign drop_o = drop_q;

endmodule

// File: rtl/ptmch_trg_gen.sv
// ---------------------------------------------------------------------------
// ptmch_trg_gen
// Snoops an SPI (mode 0) flash bus, captures the first byte of each frame as
// the opcode and fires a per-command trigger pulse for the pulse counter.
//   CLK100M   in   100 MHz system clock
//   RESET     in   asynchronous active-high reset
//   SPI_CS_N  in   snooped chip select (async)
//   SPI_SCK   in   snooped SPI clock (async)
//   SPI_MOSI  in   snooped command/data line (async)
//   TRG_PLS   out  per-channel trigger pulses
//   OPC_LAST  out  most recently decoded opcode
//   OPC_VLD   out  one-cycle strobe when OPC_LAST updates
//   DROP      out  sticky per-channel lost-trigger flags
//
// state      | meaning
// IDLE       | waiting for a CS_N fall
// OPCODE     | shifting in opcode bits on SCK rises
// WAIT_CS    | opcode done, ignoring SCK until CS_N rises
// ---------------------------------------------------------------------------
module ptmch_trg_gen
  import ptmch_pkg::*;
#(
  parameter int PLS_WIDTH = 4
) (
  input  logic              CLK100M,
  input  logic              RESET,
  input  logic              SPI_CS_N,
  input  logic              SPI_SCK,
  input  logic              SPI_MOSI,
  output logic [NUM_CH-1:0] TRG_PLS,
  output logic [7:0]        OPC_LAST,
  output logic              OPC_VLD,
  output logic [NUM_CH-1:0] DROP
);

  // Synchronizers reset to 0, so a CS_N held low through reset never looks
  // like a fall; only a fresh high-to-low transition starts a decode.
  logic [2:0] cs_sync_q;
  logic [2:0] sck_sync_q;
  logic [1:0] mosi_sync_q;

  fsm_state_t  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  opc_last_q, opc_last_d;
  logic        opc_vld_q, opc_vld_d;
  logic [7:0]  opc_new;
  logic [NUM_CH-1:0] hit;

  logic cs_fall, cs_rise, sck_rise, mosi_s;

  assign cs_fall  = cs_sync_q[2] & ~cs_sync_q[1];
  assign cs_rise  = ~cs_sync_q[2] & cs_sync_q[1];
  assign sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
  assign mosi_s   = mosi_sync_q[1];

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[1:0], SPI_CS_N};
      sck_sync_q  <= {sck_sync_q[1:0], SPI_SCK};
      mosi_sync_q <= {mosi_sync_q[0], SPI_MOSI};
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    opc_last_d = opc_last_q;
    opc_vld_d  = 1'b0;
    hit        = '0;
    opc_new    = {shift_q[6:0], mosi_s};
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_OPCODE;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      ST_OPCODE: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          shift_d   = opc_new;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d    = ST_WAIT_CS;
            opc_last_d = opc_new;
            opc_vld_d  = 1'b1;
            // decoded here so the stretch register rises together with OPC_VLD
            hit        = opc_decode(opc_new);
          end
        end
      end
      ST_WAIT_CS: begin
        if (cs_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK100M or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      opc_last_q <= 8'h00;
      opc_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      opc_last_q <= opc_last_d;
      opc_vld_q  <= opc_vld_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ptmch_pls_stretch #(
      .PLS_WIDTH (PLS_WIDTH)
    ) u_stretch (
      .clk_i  (CLK100M),
      .rst_i  (RESET),
      .hit_i  (hit[g]),
      .pls_o  (TRG_PLS[g]),
      .drop_o (DROP[g])
    );
  end

  assign OPC_LAST = opc_last_q;
  assign OPC_VLD  = opc_vld_q;

endmodule

// File: tb/tb_ptmch_trg_gen.sv
// ---------------------------------------------------------------------------
// tb_ptmch_trg_gen
// Directed SPI frames against ptmch_trg_gen with a scoreboard of expected
// opcodes/trigger masks, plus a directly driven ptmch_pls_stretch for the
// back-to-back hit case that SPI framing cannot produce.
// ---------------------------------------------------------------------------
module tb_ptmch_trg_gen;
  import ptmch_pkg::*;

  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cs_n = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;
  logic [4:0] trg;
  logic [4:0] drop;
  logic [7:0] opc_last;
  logic       opc_vld;

  logic s_hit = 1'b0;
  logic s_pls;
  logic s_drop;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] opc;
    logic [4:0] trg;
  } exp_t;
  exp_t exp_q[$];

  int rises[5];
  int s_rises = 0;

  always #5 clk = ~clk;

  ptmch_trg_gen #(.PLS_WIDTH(PW)) dut (
    .CLK100M  (clk),
    .RESET    (rst),
    .SPI_CS_N (cs_n),
    .SPI_SCK  (sck),
    .SPI_MOSI (mosi),
    .TRG_PLS  (trg),
    .OPC_LAST (opc_last),
    .OPC_VLD  (opc_vld),
    .DROP     (drop)
  );

  ptmch_pls_stretch #(.PLS_WIDTH(PW)) u_str (
    .clk_i  (clk),
    .rst_i  (rst),
    .hit_i  (s_hit),
    .pls_o  (s_pls),
    .drop_o (s_drop)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // SPI mode 0 at 10 MHz: data set while SCK low, 50 ns half periods
  task automatic spi_bits(input logic [31:0] data, input int nbits);
    cs_n = 1'b0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[nbits-1-i];
      #50 sck = 1'b1;
      #50 sck = 1'b0;
    end
    #50 cs_n = 1'b1;
    mosi = 1'b0;
    #200;
  endtask

  task automatic push_exp(input logic [7:0] opc, input logic [4:0] msk);
    exp_t e;
    e.opc = opc;
    e.trg = msk;
    exp_q.push_back(e);
  endtask

  // scoreboard monitor: one pop per OPC_VLD strobe
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && opc_vld === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_vld: OPC_LAST=0x%0h with nothing expected", opc_last);
        end else begin
          e = exp_q.pop_front();
          check("opc_last", 32'(opc_last), 32'(e.opc));
          check("trg_at_vld", 32'(trg), 32'(e.trg));
        end
      end
    end
  end

  // pulse shape monitor for the DUT channels
  initial begin
    logic [4:0] prev;
    int hi_len[5];
    int lo_len[5];
    bit seen[5];
    prev = '0;
    for (int c = 0; c < 5; c++) begin
      hi_len[c] = 0; lo_len[c] = 0; seen[c] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = '0;
        for (int c = 0; c < 5; c++) begin
          hi_len[c] = 0; lo_len[c] = 0; seen[c] = 1'b0;
        end
      end else begin
        for (int c = 0; c < 5; c++) begin
          if (trg[c]) begin
            if (!prev[c]) begin
              rises[c]++;
              if (seen[c]) check($sformatf("gap_ch%0d", c), 32'(lo_len[c] >= PW), 32'd1);
              hi_len[c] = 0;
            end
            hi_len[c]++;
          end else begin
            if (prev[c]) begin
              check($sformatf("width_ch%0d", c), 32'(hi_len[c]), 32'(PW));
              seen[c]   = 1'b1;
              lo_len[c] = 0;
            end
            lo_len[c]++;
          end
          prev[c] = trg[c];
        end
      end
    end
  end

  // pulse shape monitor for the standalone stretch: pending pulse follows the gap exactly
  initial begin
    logic sp;
    int shi;
    int slo;
    bit sseen;
    sp = 1'b0; shi = 0; slo = 0; sseen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (s_pls) begin
          if (!sp) begin
            s_rises++;
            if (sseen) check("str_gap", 32'(slo), 32'(PW));
            shi = 0;
          end
          shi++;
        end else begin
          if (sp) begin
            check("str_width", 32'(shi), 32'(PW));
            sseen = 1'b1;
            slo   = 0;
          end
          slo++;
        end
        sp = s_pls;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d expected strobes outstanding", exp_q.size());
    $fatal(1);
  end

  initial begin
    int t;
    for (int c = 0; c < 5; c++) rises[c] = 0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_trg", 32'(trg), 32'd0);
    check("rst_opc_last", 32'(opc_last), 32'd0);
    check("rst_opc_vld", 32'(opc_vld), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // program execute with three address bytes
    push_exp(8'h10, 5'b00001);
    spi_bits({8'h10, 8'h00, 8'h12, 8'h34}, 32);
    repeat (10) @(negedge clk);
    check("prgexct_rises_ch0", 32'(rises[0]), 32'd1);
    check("prgexct_other_ch", 32'(rises[1] + rises[2] + rises[3] + rises[4]), 32'd0);

    // two read-status variants 2 us apart
    push_exp(8'h05, 5'b00010);
    spi_bits(32'h05, 8);
    #2000;
    push_exp(8'h0F, 5'b00010);
    spi_bits(32'h0F, 8);
    repeat (10) @(negedge clk);
    check("rdstat_count", 32'(rises[1]), 32'd2);

    // three hits within 6 cycles on a standalone channel
    @(negedge clk) s_hit = 1'b1;
    @(negedge clk) s_hit = 1'b0;
    @(negedge clk) s_hit = 1'b1;
    @(negedge clk) s_hit = 1'b0;
    check("str_drop_before_3rd", 32'(s_drop), 32'd0);
    @(negedge clk) s_hit = 1'b1;
    @(negedge clk) s_hit = 1'b0;
    repeat (20) @(negedge clk);
    check("str_pulses", 32'(s_rises), 32'd2);
    check("str_drop", 32'(s_drop), 32'd1);

    // aborted frame after 5 bits, then a full page-data-read
    spi_bits(32'h02, 5);
    repeat (10) @(negedge clk);
    check("abort_no_trg", 32'(rises[3]), 32'd0);
    check("abort_opc_last", 32'(opc_last), 32'h0F);
    push_exp(8'h13, 5'b01000);
    spi_bits(32'h13, 8);
    repeat (10) @(negedge clk);
    check("pdread_rises_ch3", 32'(rises[3]), 32'd1);

    // unmapped opcode
    push_exp(8'h9F, 5'b00000);
    spi_bits(32'h9F, 8);
    repeat (10) @(negedge clk);
    check("unmapped_opc_last", 32'(opc_last), 32'h9F);
    check("unmapped_total_rises", 32'(rises[0] + rises[1] + rises[2] + rises[3] + rises[4]), 32'd4);
    check("drop_clear", 32'(drop), 32'd0);

    // reset during the 2nd cycle of a write-status pulse
    push_exp(8'h01, 5'b10000);
    fork
      spi_bits(32'h01, 8);
      begin
        t = 0;
        while (trg[4] !== 1'b1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        check("wrstat_pulse_seen", 32'(trg[4]), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_kills_trg4", 32'(trg[4]), 32'd0);
        check("rst_clears_opc", 32'(opc_last), 32'd0);
        #27 rst = 1'b0;
      end
    join
    repeat (30) @(negedge clk);
    check("no_pulse_after_rst", 32'(rises[4]), 32'd1);
    check("trg_idle_after_rst", 32'(trg), 32'd0);
    check("no_decode_after_rst", 32'(opc_last), 32'd0);
    check("all_strobes_seen", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
